// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the block RAM.
// The arbiter connects through the slave modport; the core/RAM side uses master.
interface riscv_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  imem_req_in;
    logic [31:0]           imem_addr_in;
    logic                  imem_ready_out;
    logic                  imem_valid_out;
    logic [31:0]           imem_data_out;

    logic                  dmem_req_in;
    logic                  dmem_we_in;
    logic [31:0]           dmem_addr_in;
    logic [31:0]           dmem_wdata_in;
    logic [2:0]            dmem_size_in;
    logic                  dmem_ready_out;
    logic                  dmem_valid_out;
    logic [31:0]           dmem_rdata_out;
    logic                  dmem_misaligned_out;

    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [31:0]           mem_wdata_out;
    logic [3:0]            mem_we_out;
    logic [31:0]           mem_rdata_in;

    modport slave (
        input  imem_req_in, imem_addr_in,
        input  dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in, dmem_size_in,
        input  mem_rdata_in,
        output imem_ready_out, imem_valid_out, imem_data_out,
        output dmem_ready_out, dmem_valid_out, dmem_rdata_out, dmem_misaligned_out,
        output mem_addr_out, mem_wdata_out, mem_we_out
    );

    modport master (
        output imem_req_in, imem_addr_in,
        output dmem_req_in, dmem_we_in, dmem_addr_in, dmem_wdata_in, dmem_size_in,
        output mem_rdata_in,
        input  imem_ready_out, imem_valid_out, imem_data_out,
        input  dmem_ready_out, dmem_valid_out, dmem_rdata_out, dmem_misaligned_out,
        input  mem_addr_out, mem_wdata_out, mem_we_out
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-port fixed-latency block RAM:
// alternating-priority grant, store lane steering, tagged read return with extension.
module riscv_mem_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    riscv_mem_arbiter_if.slave bus
);
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       owner;   // 1 = dmem
        logic [2:0] size;
        logic [1:0] offset;
    } tag_t;

    logic        last_dmem;
    logic        grant_d;
    logic        grant_i;
    logic        is_byte;
    logic        is_half;
    logic        misaligned;
    logic        issue_d;
    logic [1:0]  a;
    logic [3:0]  lane_be;
    tag_t        push_tag;
    tag_t        tags [READ_LATENCY];
    tag_t        tail;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic        unused_addr_bits;

    always_comb begin
        a       = bus.dmem_addr_in[1:0];
        is_byte = bus.dmem_size_in inside {MASK_B, MASK_BU};
        is_half = bus.dmem_size_in inside {MASK_H, MASK_HU};
        // Any size code that is neither byte nor halfword is handled as a word.
        misaligned = is_half ? a[0] : (!is_byte && (a != 2'b00));

        grant_d = rst_n_in && bus.dmem_req_in && (!bus.imem_req_in || !last_dmem);
        grant_i = rst_n_in && bus.imem_req_in && !grant_d;
        issue_d = grant_d && !misaligned;

        if (is_byte) begin
            lane_be           = 4'b0001 << a;
            bus.mem_wdata_out = {4{bus.dmem_wdata_in[7:0]}};
        end else if (is_half) begin
            lane_be           = 4'b0011 << {a[1], 1'b0};
            bus.mem_wdata_out = {2{bus.dmem_wdata_in[15:0]}};
        end else begin
            lane_be           = 4'b1111;
            bus.mem_wdata_out = bus.dmem_wdata_in;
        end

        bus.mem_we_out   = (issue_d && bus.dmem_we_in) ? lane_be : 4'b0000;
        bus.mem_addr_out = grant_d ? bus.dmem_addr_in[ADDR_WIDTH+1:2]
                                   : bus.imem_addr_in[ADDR_WIDTH+1:2];

        bus.imem_ready_out      = grant_i;
        bus.dmem_ready_out      = grant_d;
        bus.dmem_misaligned_out = grant_d && misaligned;

        push_tag.valid  = grant_i || (issue_d && !bus.dmem_we_in);
        push_tag.owner  = grant_d;
        push_tag.size   = bus.dmem_size_in;
        push_tag.offset = a;
    end

    assign unused_addr_bits = ^{bus.imem_addr_in[1:0],
                                bus.imem_addr_in[31:ADDR_WIDTH+2],
                                bus.dmem_addr_in[31:ADDR_WIDTH+2]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_dmem <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) tags[i] <= '0;
        end else begin
            if (grant_d || grant_i) last_dmem <= grant_d;
            tags[0] <= push_tag;
            for (int i = 1; i < READ_LATENCY; i++) tags[i] <= tags[i-1];
        end
    end

    // The tag at the tail lines up with the RAM data for the read it describes.
    always_comb begin
        tail   = tags[READ_LATENCY-1];
        lane_b = bus.mem_rdata_in[{tail.offset, 3'b000} +: 8];
        lane_h = bus.mem_rdata_in[{tail.offset[1], 4'b0000} +: 16];
        if (tail.size == MASK_B)
            load_ext = {{24{lane_b[7]}}, lane_b};
        else if (tail.size == MASK_BU)
            load_ext = {24'h0, lane_b};
        else if (tail.size == MASK_H)
            load_ext = {{16{lane_h[15]}}, lane_h};
        else if (tail.size == MASK_HU)
            load_ext = {16'h0, lane_h};
        else
            load_ext = bus.mem_rdata_in;

        bus.imem_valid_out = tail.valid && !tail.owner;
        bus.dmem_valid_out = tail.valid && tail.owner;
        bus.imem_data_out  = bus.imem_valid_out ? bus.mem_rdata_in : 32'h0;
        bus.dmem_rdata_out = bus.dmem_valid_out ? load_ext : 32'h0;
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized scoreboard bench for riscv_mem_arbiter against a byte-level memory model.
module tb_riscv_mem_arbiter;
    localparam int AW = 14;
    localparam int L  = 2;
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    riscv_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus();

    riscv_mem_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(L)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // Block RAM model: write on the edge, read data L cycles after the address.
    logic [31:0] ram  [0:255];
    logic [31:0] rd_q [L];
    always @(posedge clk_in) begin
        for (int i = L - 1; i > 0; i--) rd_q[i] <= rd_q[i-1];
        rd_q[0] <= ram[bus.mem_addr_out[7:0]];
        for (int b = 0; b < 4; b++)
            if (bus.mem_we_out[b]) ram[bus.mem_addr_out[7:0]][8*b +: 8] <= bus.mem_wdata_out[8*b +: 8];
    end
    assign bus.mem_rdata_in = rd_q[L-1];

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Reference state: byte memory, who was granted last, expected responses.
    logic [7:0] mem_b [0:255];
    logic       ref_last_d = 1'b0;
    exp_t       exp_i[$];
    exp_t       exp_d[$];
    byte        grant_log[$];

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] sz);
        logic [7:0] p;
        p = addr[7:0];
        case (sz)
            MASK_B:  return {{24{mem_b[p][7]}}, mem_b[p]};
            MASK_BU: return {24'h0, mem_b[p]};
            MASK_H:  return {{16{mem_b[p+8'd1][7]}}, mem_b[p+8'd1], mem_b[p]};
            MASK_HU: return {16'h0, mem_b[p+8'd1], mem_b[p]};
            default: return {mem_b[p+8'd3], mem_b[p+8'd2], mem_b[p+8'd1], mem_b[p]};
        endcase
    endfunction

    always @(negedge clk_in) begin
        logic        want_d, want_i, mis;
        logic [1:0]  a;
        logic [2:0]  sz;
        logic [31:0] ad, wd, exp_wd;
        logic [3:0]  exp_be;
        int          nbytes;
        if (!rst_n_in) begin
            check("reset_ctrl", {bus.imem_ready_out, bus.dmem_ready_out, bus.imem_valid_out,
                                 bus.dmem_valid_out, bus.dmem_misaligned_out, bus.mem_we_out}, 0);
            check("reset_data", bus.imem_data_out | bus.dmem_rdata_out, 0);
            ref_last_d = 1'b0;
            exp_i.delete();
            exp_d.delete();
        end else begin
            if (bus.dmem_req_in && bus.imem_req_in) begin
                want_d = !ref_last_d;
                want_i = ref_last_d;
            end else begin
                want_d = bus.dmem_req_in;
                want_i = bus.imem_req_in;
            end
            check("arb_grant", {bus.imem_ready_out, bus.dmem_ready_out}, {want_i, want_d});
            if (want_d) begin
                ad = bus.dmem_addr_in;
                a  = ad[1:0];
                sz = bus.dmem_size_in;
                wd = bus.dmem_wdata_in;
                nbytes = (sz == MASK_B || sz == MASK_BU) ? 1 : (sz == MASK_H || sz == MASK_HU) ? 2 : 4;
                mis = (ad % nbytes) != 0;
                check("misaligned", bus.dmem_misaligned_out, mis);
                if (mis) begin
                    check("mis_we", bus.mem_we_out, 0);
                end else begin
                    check("d_addr", bus.mem_addr_out, ad[AW+1:2]);
                    if (bus.dmem_we_in) begin
                        exp_be = 4'b0;
                        for (int k = 0; k < nbytes; k++) exp_be[a + k] = 1'b1;
                        exp_wd = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
                        check("st_be", bus.mem_we_out, exp_be);
                        check("st_wdata", bus.mem_wdata_out, exp_wd);
                        for (int k = 0; k < nbytes; k++) mem_b[ad[7:0] + k] = wd[8*k +: 8];
                    end else begin
                        check("ld_we", bus.mem_we_out, 0);
                        exp_d.push_back('{due: cyc + L, data: ref_load(ad, sz)});
                    end
                end
                ref_last_d = 1'b1;
                grant_log.push_back("d");
            end else if (want_i) begin
                ad = bus.imem_addr_in;
                check("i_addr", bus.mem_addr_out, ad[AW+1:2]);
                check("i_we", bus.mem_we_out, 0);
                exp_i.push_back('{due: cyc + L, data: ref_load({ad[31:2], 2'b00}, MASK_W)});
                ref_last_d = 1'b0;
                grant_log.push_back("i");
            end else begin
                check("idle_we", bus.mem_we_out, 0);
            end
        end
    end

    // Response monitor.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (bus.imem_valid_out) begin
                if (exp_i.size() == 0) fail("i_unexpected", "valid with nothing outstanding");
                else begin
                    e = exp_i.pop_front();
                    check("i_due", cyc, e.due);
                    check("i_data", bus.imem_data_out, e.data);
                end
            end else if (exp_i.size() != 0 && exp_i[0].due <= cyc) begin
                void'(exp_i.pop_front());
                fail("i_missing", "no valid, required one");
            end
            if (bus.dmem_valid_out) begin
                if (exp_d.size() == 0) fail("d_unexpected", "valid with nothing outstanding");
                else begin
                    e = exp_d.pop_front();
                    check("d_due", cyc, e.due);
                    check("d_data", bus.dmem_rdata_out, e.data);
                end
            end else if (exp_d.size() != 0 && exp_d[0].due <= cyc) begin
                void'(exp_d.pop_front());
                fail("d_missing", "no valid, required one");
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        bus.imem_addr_in = addr;
        bus.imem_req_in  = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_in);
            if (bus.imem_ready_out) break;
            if (n == 30) begin
                fail("i_accept", "no ready within 30 cycles");
                break;
            end
        end
        @(posedge clk_in);
        #1;
        bus.imem_req_in = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] sz);
        bus.dmem_we_in    = we;
        bus.dmem_addr_in  = addr;
        bus.dmem_wdata_in = wdata;
        bus.dmem_size_in  = sz;
        bus.dmem_req_in   = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk_in);
            if (bus.dmem_ready_out) break;
            if (n == 30) begin
                fail("d_accept", "no ready within 30 cycles");
                break;
            end
        end
        @(posedge clk_in);
        #1;
        bus.dmem_req_in = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n_in = 1'b0;
        idle(2);
        rst_n_in = 1'b1;
        idle(1);
    endtask

    logic [2:0] sizes [5] = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        bus.imem_req_in   = 1'b0;
        bus.imem_addr_in  = 32'h0;
        bus.dmem_req_in   = 1'b0;
        bus.dmem_we_in    = 1'b0;
        bus.dmem_addr_in  = 32'h0;
        bus.dmem_wdata_in = 32'h0;
        bus.dmem_size_in  = MASK_W;
        idle(3);
        rst_n_in = 1'b1;
        idle(1);

        for (int w = 0; w < 64; w++) do_data(1'b1, w * 4, $urandom, MASK_W);

        // Single fetch
        do_data(1'b1, 32'h10, 32'h00500093, MASK_W);
        do_fetch(32'h10);

        // Signed / unsigned extraction
        do_data(1'b1, 32'h20, 32'h80FF7F01, MASK_W);
        do_data(1'b0, 32'h22, 32'h0, MASK_B);
        do_data(1'b0, 32'h23, 32'h0, MASK_BU);
        do_data(1'b0, 32'h22, 32'h0, MASK_H);
        do_data(1'b0, 32'h20, 32'h0, MASK_HU);
        do_data(1'b0, 32'h20, 32'h0, MASK_W);

        // Byte-lane stores
        do_data(1'b1, 32'h25, 32'h123456AB, MASK_B);
        do_data(1'b1, 32'h26, 32'hDEAD1234, MASK_H);
        do_data(1'b0, 32'h24, 32'h0, MASK_W);

        // Misaligned drops
        do_data(1'b1, 32'h2A, 32'hFFFFFFFF, MASK_W);
        do_data(1'b0, 32'h29, 32'h0, MASK_H);
        do_data(1'b0, 32'h21, 32'h0, MASK_W);
        idle(4);

        // Contention from reset
        pulse_reset();
        grant_log.delete();
        fork
            for (int k = 0; k < 3; k++) do_data(1'b0, $urandom_range(0, 63) * 4, 32'h0, MASK_W);
            for (int k = 0; k < 3; k++) do_fetch($urandom_range(0, 255));
        join
        check("grant_count", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size(); k++)
            check("grant_seq", grant_log[k], (k % 2 == 0) ? "d" : "i");
        idle(4);

        // Reset one cycle after a load is accepted
        do_data(1'b0, 32'h20, 32'h0, MASK_W);
        rst_n_in = 1'b0;
        bus.imem_req_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        bus.imem_req_in = 1'b0;
        idle(6);
        grant_log.delete();
        fork
            do_data(1'b0, 32'h10, 32'h0, MASK_W);
            do_fetch(32'h10);
        join
        check("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : 8'h0, "d");
        idle(4);

        // Randomized traffic on both ports
        fork
            for (int k = 0; k < 200; k++) begin
                idle($urandom_range(0, 2));
                do_fetch($urandom_range(0, 255));
            end
            for (int k = 0; k < 200; k++) begin
                logic [2:0]  sz;
                logic [31:0] ad;
                sz = sizes[$urandom_range(0, 4)];
                ad = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == MASK_W) ad[1:0] = 2'b00;
                    else if (sz == MASK_H || sz == MASK_HU) ad[0] = 1'b0;
                end
                idle($urandom_range(0, 2));
                do_data($urandom_range(0, 1), ad, $urandom, sz);
            end
        join

        idle(10);
        check("drain_i", exp_i.size(), 0);
        check("drain_d", exp_d.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one single-port, fixed-latency block RAM between the instruction-fetch port and the load/store port of the core. It performs request arbitration and store byte-lane steering. It returns load data extracted, sign- or zero-extended, and routed to the requester that issued the read. It consumes the `dmem_size`, `dmem_read_enable` and `dmem_write_enable` controls produced by instruction decode, using the `MASK_*` encodings from `riscv_constants.sv`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: word-address width of the RAM.
- `READ_LATENCY`, default 2: cycles from address presented to `mem_rdata_in` valid. Legal range 1–4.

Ports:
- `clk_in`  input  1  clock. One clock domain.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `imem_req_in`  input  1  fetch request; held until accepted.
- `imem_addr_in`  input  32  fetch byte address. Bits [1:0] are ignored.
- `imem_ready_out`  output  1  fetch accepted this cycle.
- `imem_valid_out`  output  1  fetch data valid.
- `imem_data_out`  output  32  instruction word.
- `dmem_req_in`  input  1  data request; held until accepted.
- `dmem_we_in`  input  1  1 = store, 0 = load.
- `dmem_addr_in`  input  32  data byte address.
- `dmem_wdata_in`  input  32  store data, right-aligned.
- `dmem_size_in`  input  3  one of `MASK_B`, `MASK_H`, `MASK_W`, `MASK_BU`, `MASK_HU`.
- `dmem_ready_out`  output  1  data request accepted this cycle.
- `dmem_valid_out`  output  1  load data valid.
- `dmem_rdata_out`  output  32  extended load data.
- `dmem_misaligned_out`  output  1  accepted request was misaligned and dropped.
- `mem_addr_out`  output  ADDR_WIDTH  RAM word address, equal to `addr[ADDR_WIDTH+1:2]`.
- `mem_wdata_out`  output  32  lane-steered store data.
- `mem_we_out`  output  4  byte write enables.
- `mem_rdata_in`  input  32  RAM read data.

## Operation
- **Acceptance.** A request is accepted in a cycle where `req_in` and `ready_out` are both high at the rising edge. At most one request is accepted per cycle. Requests are pipelined: a new request may be accepted every cycle regardless of reads in flight.
- **Arbitration.** If only one port requests, it is granted. If both request, the port not granted most recently wins. The `last_grant` register updates only on an accept. It resets to imem, so dmem wins the first contention. A port that has not been granted is never starved for more than 1 cycle.
- **Ready timing.** `ready_out` is combinational from the two `req_in` signals and `last_grant`.
- **RAM drive.** `mem_addr_out`, `mem_we_out` and `mem_wdata_out` are combinational from the granted request. With no grant, `mem_we_out` is 0 and `mem_addr_out` is don't-care.
- **Store byte enables** (`a = dmem_addr_in[1:0]`):
  - `MASK_B` or `MASK_BU`: `mem_we_out = 4'b0001 << a`; the byte is replicated in all 4 lanes.
  - `MASK_H` or `MASK_HU`: `mem_we_out = 4'b0011 << (2*a[1])`; the halfword is replicated in both halves.
  - `MASK_W`: `mem_we_out = 4'b1111`.
- **Misalignment.** A halfword access with `a[0]=1`, or a word access with `a != 0`, is accepted but not issued. `mem_we_out` stays 0 and no read is tracked. `dmem_misaligned_out` pulses high in the accept cycle.
- **Read tracking.** Each accepted, non-misaligned read pushes a tag `{valid, owner, size, a}` into a `READ_LATENCY`-deep shift register. Stores and misaligned requests push an invalid tag.
- **Load extraction.**
  - A tag reaching the end of the shift register selects the byte or halfword from `mem_rdata_in` at offset `a`.
  - `MASK_B` and `MASK_H` sign-extend; `MASK_BU` and `MASK_HU` zero-extend; `MASK_W` passes the word through.
  - Fetches always return the full word.
- **Response routing.** The result appears on the owner's data output with that port's `valid_out` high. The other port's `valid_out` stays 0.
- **Response order.** Responses return in issue order, one per cycle at most.

## Timing
- **Reset.** While `rst_n_in=0`, all tags are cleared and `last_grant` is imem. All of the following are 0: `imem_ready_out`, `dmem_ready_out`, `imem_valid_out`, `dmem_valid_out`, `dmem_misaligned_out`, `mem_we_out`, `imem_data_out`, `dmem_rdata_out`.
- **Reset mid-operation.** A read accepted before reset produces no valid after reset deasserts. Reset asserted mid-cycle forces the outputs to 0 immediately (asynchronous).
- **Read latency.** A read accepted at edge t gives valid high for exactly the cycle after edge t+`READ_LATENCY`−1, i.e. `READ_LATENCY` cycles after the accept cycle.
- **Store completion.** A store takes effect at the RAM on the accept edge. There is no response.
- **Back-to-back.** Reads accepted on consecutive edges produce valids on consecutive cycles.
- **Pipeline depth.** Occupancy is fixed by the shift register, so there is no full or empty stall condition.
- **Simultaneous events.** If both ports request in every cycle, grants alternate dmem, imem, dmem, and so on, starting with dmem after reset.
- **Request stability.** A requester must keep `addr`, `we`, `wdata` and `size` stable while `req` is high and not yet accepted. The arbiter does not register requests.

## Test plan
- **Single fetch.** Reset, then imem requests `addr=0x10` with RAM word 4 = `0x00500093`. Required: ready is high the same cycle; `imem_valid_out` is high 2 cycles later with `0x00500093`.
- **Contention.** Both ports request continuously for 6 cycles. Required: grant sequence d, i, d, i, d, i; each response returns to the correct port in order.
- **Signed byte load.** Word = `0x80FF7F01`; `LB` at `addr=0x..2` returns `0xFFFFFFFF`. `LBU` at `0x..3` returns `0x00000080`. `LH` at `0x..2` returns `0xFFFF80FF`.
- **Byte-lane stores.** `SB` of `0xAB` at `0x..1` gives `mem_we_out=0010` and wdata `0xABABABAB`. `SH` of `0x1234` at `0x..2` gives `mem_we_out=1100`.
- **Misalignment.** `SW` at `0x..2` and `LH` at `0x..1`. Required: one-cycle `dmem_misaligned_out` pulse each, `mem_we_out=0`, no `dmem_valid_out`.
- **Reset mid-flight.** Assert `rst_n_in` low 1 cycle after accepting a load, then release. Required: no `dmem_valid_out` ever appears; the next contention grants dmem first.
